// File: rtl/loader_uart_pkg.sv
// Shared definitions for the loader UART link (transmit streamer and receiver).
// State encoding includes PARITY, used only when UART_PARITY_EN is defined.
package loader_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic        UART_IDLE_LVL = 1'b1;
   localparam int unsigned BITS_PER_CHAR = 8;
   localparam int unsigned FIFO_ENTRY_W  = 9;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   // Legal byte enables are contiguous from bit0 and non-empty.
   function automatic logic keep_contiguous(input logic [3:0] keep);
      return (keep == 4'b0001) || (keep == 4'b0011) ||
             (keep == 4'b0111) || (keep == 4'b1111);
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Baud counter, frame FSM and shift register for one UART character (8N1).
// Defining UART_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_serializer
   import loader_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en_i,
   input  logic [7:0] byte_i,
   input  logic       last_i,
   input  logic       valid_i,
   output logic       ready_c_o,
   output logic       busy_c_o,
   output logic       tx_o,
   output logic       frame_done_o,
   output logic       frame_last_o
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IW = $clog2(BITS_PER_CHAR);

   uart_state_e              state_q;
   logic [CW-1:0]            cnt_q;
   logic [IW-1:0]            idx_q;
   logic [BITS_PER_CHAR-1:0] shift_q;
   logic                     last_q;
   logic                     bit_end_c;
   logic                     take_c;
`ifdef UART_PARITY_EN
   logic                     par_q;
`endif

   assign bit_end_c = (cnt_q == CW'(CLKS_PER_BIT - 1));
   // A new byte is taken from idle or on the final cycle of STOP, so frames abut.
   assign ready_c_o = tx_en_i &
                      ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end_c));
   assign take_c    = ready_c_o & valid_i;
   assign busy_c_o  = (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         last_q       <= 1'b0;
         tx_o         <= UART_IDLE_LVL;
         frame_done_o <= 1'b0;
         frame_last_o <= 1'b0;
`ifdef UART_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         frame_done_o <= 1'b0;
         frame_last_o <= 1'b0;
         cnt_q        <= bit_end_c ? '0 : cnt_q + CW'(1);

         if (take_c) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            tx_o    <= 1'b0;
            shift_q <= byte_i;
            last_q  <= last_i;
`ifdef UART_PARITY_EN
            par_q   <= ^byte_i;
`endif
         end

         case (state_q)
            ST_IDLE: begin
               if (!take_c) begin
                  cnt_q <= '0;
               end
            end
            ST_START: begin
               if (bit_end_c) begin
                  state_q <= ST_DATA;
                  idx_q   <= '0;
                  tx_o    <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (bit_end_c) begin
                  if (idx_q == IW'(BITS_PER_CHAR - 1)) begin
`ifdef UART_PARITY_EN
                     state_q <= ST_PARITY;
                     tx_o    <= par_q;
`else
                     state_q <= ST_STOP;
                     tx_o    <= UART_IDLE_LVL;
`endif
                  end else begin
                     idx_q   <= idx_q + IW'(1);
                     shift_q <= shift_q >> 1;
                     tx_o    <= shift_q[1];
                  end
               end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
               if (bit_end_c) begin
                  state_q <= ST_STOP;
                  tx_o    <= UART_IDLE_LVL;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end_c) begin
                  frame_done_o <= 1'b1;
                  frame_last_o <= last_q;
                  if (!take_c) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_o    <= UART_IDLE_LVL;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_streamer.sv
// Word-stream to UART transmitter: unpacker, byte FIFO, serializer and counters.
// Defining UART_PARITY_EN selects 8E1 frames in the serializer.
module uart_tx_streamer
   import loader_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic [3:0]  s_keep,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        tx_en,
   output logic        uart_tx,
   output logic        busy,
   output logic        done,
   output logic [15:0] byte_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   fifo_entry_t   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;

   logic [31:0]   hold_data_q;
   logic [3:0]    hold_keep_q;
   logic          hold_last_q;
   logic          hold_v_q;
   logic          s_ready_q;

   logic          busy_q;
   logic          done_q;
   logic          pend_done_q;
   logic [15:0]   byte_count_q;

   logic          fifo_empty_c;
   logic          fifo_full_c;
   logic          push_c;
   logic          pop_c;
   logic          accept_c;
   logic          drained_c;
   fifo_entry_t   push_entry_c;
   fifo_entry_t   head_c;

   logic          ser_ready_c;
   logic          ser_busy_c;
   logic          frame_done;
   logic          frame_last;

   assign fifo_empty_c = (cnt_q == '0);
   assign fifo_full_c  = (cnt_q == FULL_CNT);
   assign pop_c        = ser_ready_c & ~fifo_empty_c;
   assign push_c       = hold_v_q & (~fifo_full_c | pop_c);
   assign accept_c     = s_valid & s_ready_q;
   assign drained_c    = fifo_empty_c & ~hold_v_q & ~ser_busy_c;
   assign head_c       = mem_q[rd_ptr_q];
   // Only the word's final enabled byte carries the stream's last flag.
   assign push_entry_c = '{last: hold_last_q & ~hold_keep_q[1], data: hold_data_q[7:0]};

   // Byte FIFO storage (no reset needed on the data array).
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= push_entry_c;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_c, pop_c})
            2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Unpacker: one word held, one byte shifted out per push.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_q <= '0;
         hold_keep_q <= '0;
         hold_last_q <= 1'b0;
         hold_v_q    <= 1'b0;
         s_ready_q   <= 1'b0;
      end else begin
         if (push_c) begin
            hold_data_q <= hold_data_q >> 8;
            hold_keep_q <= hold_keep_q >> 1;
            if (!hold_keep_q[1]) begin
               hold_v_q  <= 1'b0;
               s_ready_q <= 1'b1;
            end
         end else if (!hold_v_q) begin
            s_ready_q <= 1'b1;
         end
         if (accept_c && keep_contiguous(s_keep)) begin
            hold_data_q <= s_data;
            hold_keep_q <= s_keep;
            hold_last_q <= s_last;
            hold_v_q    <= 1'b1;
            s_ready_q   <= 1'b0;
         end
      end
   end

   // Status: byte counter, done pulse (including empty last words), busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_count_q <= '0;
         done_q       <= 1'b0;
         pend_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         busy_q <= ~fifo_empty_c | hold_v_q | ser_busy_c;
         if (frame_done) begin
            byte_count_q <= byte_count_q + 16'd1;
            if (frame_last) begin
               done_q <= 1'b1;
            end
            if (pend_done_q && drained_c) begin
               done_q      <= 1'b1;
               pend_done_q <= 1'b0;
            end
         end
         // An empty last word ends the stream once earlier bytes have left the line.
         if (accept_c && s_last && (s_keep == 4'd0)) begin
            if (drained_c) begin
               done_q <= 1'b1;
            end else begin
               pend_done_q <= 1'b1;
            end
         end
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_serializer (
      .clk          (clk),
      .rst          (rst),
      .tx_en_i      (tx_en),
      .byte_i       (head_c.data),
      .last_i       (head_c.last),
      .valid_i      (~fifo_empty_c),
      .ready_c_o    (ser_ready_c),
      .busy_c_o     (ser_busy_c),
      .tx_o         (uart_tx),
      .frame_done_o (frame_done),
      .frame_last_o (frame_last)
   );

   assign s_ready    = s_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Directed bench for uart_tx_streamer: decodes the serial line and checks bytes,
// timing, done pulses and counters. Honours UART_PARITY_EN for frame layout.
module tb_uart_tx_streamer;

   localparam int unsigned CPB = 4;
`ifdef UART_PARITY_EN
   localparam int unsigned FRAME = CPB * 11;
`else
   localparam int unsigned FRAME = CPB * 10;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        tx_en;
   logic        uart_tx;
   logic        busy;
   logic        done;
   logic [15:0] byte_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned done_cnt = 0;
   int unsigned done_cyc = 0;
   int unsigned stall_cnt = 0;

   logic [7:0]  rx_q[$];
   logic        par_q[$];
   logic        stop_q[$];
   int unsigned start_q[$];

   uart_tx_streamer #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_keep     (s_keep),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .tx_en      (tx_en),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .done       (done),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (s_valid === 1'b1 && s_ready === 1'b0) stall_cnt = stall_cnt + 1;
   end

   // Line decoder: samples mid-bit on the falling clock edge.
   initial begin : line_mon
      logic [7:0] b;
      logic       p;
      logic       s;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            start_q.push_back(cyc);
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = uart_tx;
               repeat (CPB) @(negedge clk);
            end
            p = 1'b0;
`ifdef UART_PARITY_EN
            p = uart_tx;
            repeat (CPB) @(negedge clk);
`endif
            s = uart_tx;
            rx_q.push_back(b);
            par_q.push_back(p);
            stop_q.push_back(s);
            repeat (CPB / 2 - 1) @(negedge clk);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      par_q.delete();
      stop_q.delete();
      start_q.delete();
      done_cnt  = 0;
      stall_cnt = 0;
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance, s_valid left high.
   task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n = 0;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check_eq("send_timeout", 32'(n), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk);
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check_eq("idle_timeout", 32'(n), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_starts(input int unsigned cnt);
      int n = 0;
      while (start_q.size() < cnt && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check_eq("start_timeout", 32'(n), 32'd0);
   endtask

   task automatic check_rx(input string tag, input int unsigned idx, input logic [7:0] exp);
      if (idx < rx_q.size()) begin
         check_eq(tag, 32'(rx_q[idx]), 32'(exp));
         check_eq({tag, "_stop"}, 32'(stop_q[idx]), 32'd1);
      end else begin
         check_eq({tag, "_missing"}, 32'(rx_q.size()), 32'(idx + 1));
      end
   endtask

   initial begin : main
      logic [7:0]  abcd [4];
      int unsigned bc0;
      int unsigned low_cnt;
      abcd = '{8'h41, 8'h42, 8'h43, 8'h44};

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; tx_en = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_byte_count", 32'(byte_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Full word, four bytes, no gaps, single done.
      clear_mon();
      bc0 = 32'(byte_count);
      send_word(32'h44434241, 4'hF, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      check_eq("t1_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_rx($sformatf("t1_byte%0d", i), i, abcd[i]);
      for (int i = 1; i < 4 && i < start_q.size(); i++)
         check_eq($sformatf("t1_gap%0d", i), start_q[i] - start_q[i-1], FRAME);
      check_eq("t1_done_cnt", done_cnt, 32'd1);
      if (start_q.size() == 4)
         check_eq("t1_done_after_stop",
                  32'((done_cyc >= start_q[3] + FRAME) && (done_cyc <= start_q[3] + FRAME + 2)), 32'd1);
      check_eq("t1_byte_count", 32'(byte_count), bc0 + 4);

      // Partial word: two bytes only.
      clear_mon();
      bc0 = 32'(byte_count);
      send_word(32'h00000A31, 4'h3, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      check_eq("t2_count", 32'(rx_q.size()), 32'd2);
      check_rx("t2_byte0", 0, 8'h31);
      check_rx("t2_byte1", 1, 8'h0A);
      check_eq("t2_done_cnt", done_cnt, 32'd1);
      check_eq("t2_byte_count", 32'(byte_count), bc0 + 2);

      // Three words back to back; FIFO fills and s_ready stalls.
      clear_mon();
      send_word(32'h04030201, 4'hF, 1'b0);
      send_word(32'h08070605, 4'hF, 1'b0);
      send_word(32'h0C0B0A09, 4'hF, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      check_eq("t3_stall", 32'(stall_cnt > 20), 32'd1);
      check_eq("t3_count", 32'(rx_q.size()), 32'd12);
      for (int i = 0; i < 12; i++) check_rx($sformatf("t3_byte%0d", i), i, 8'(i + 1));
      check_eq("t3_done_cnt", done_cnt, 32'd1);

      // tx_en dropped during the second frame.
      clear_mon();
      bc0 = 32'(byte_count);
      send_word(32'h44434241, 4'hF, 1'b1);
      s_valid = 1'b0;
      wait_starts(2);
      repeat (4) @(negedge clk);
      tx_en = 1'b0;
      low_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (i >= FRAME && uart_tx !== 1'b1) low_cnt++;
      end
      check_eq("t4_held_count", 32'(rx_q.size()), 32'd2);
      check_rx("t4_byte1", 1, 8'h42);
      check_eq("t4_line_high", low_cnt, 32'd0);
      check_eq("t4_busy_held", 32'(busy), 32'd1);
      tx_en = 1'b1;
      wait_idle();
      check_eq("t4_count", 32'(rx_q.size()), 32'd4);
      check_rx("t4_byte2", 2, 8'h43);
      check_rx("t4_byte3", 3, 8'h44);
      check_eq("t4_done_cnt", done_cnt, 32'd1);
      check_eq("t4_byte_count", 32'(byte_count), bc0 + 4);

      // Reset in the middle of a data bit, then a fresh byte.
      clear_mon();
      send_word(32'h44434241, 4'hF, 1'b1);
      s_valid = 1'b0;
      wait_starts(1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t5_rst_uart_tx", 32'(uart_tx), 32'd1);
      check_eq("t5_rst_busy", 32'(busy), 32'd0);
      check_eq("t5_rst_byte_count", 32'(byte_count), 32'd0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      clear_mon();
      send_word(32'h0000005A, 4'h1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      check_eq("t5_count", 32'(rx_q.size()), 32'd1);
      check_rx("t5_byte0", 0, 8'h5A);
      check_eq("t5_done_cnt", done_cnt, 32'd1);
      check_eq("t5_byte_count", 32'(byte_count), 32'd1);

      // Empty last word pulses done at once; non-contiguous word is dropped.
      clear_mon();
      send_word(32'hDEADBEEF, 4'h0, 1'b1);
      s_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t7_keep0_done", done_cnt, 32'd1);
      send_word(32'h0000FFFF, 4'b0101, 1'b0);
      s_valid = 1'b0;
      repeat (FRAME + 10) @(negedge clk);
      check_eq("t7_discard_count", 32'(rx_q.size()), 32'd0);
      check_eq("t7_discard_done", done_cnt, 32'd1);
      check_eq("t7_s_ready", 32'(s_ready), 32'd1);
      check_eq("t7_byte_count", 32'(byte_count), 32'd1);

`ifdef UART_PARITY_EN
      // Even parity for 8'h07 is 1.
      clear_mon();
      send_word(32'h00000007, 4'h1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      check_rx("t6_byte0", 0, 8'h07);
      if (par_q.size() > 0) check_eq("t6_parity", 32'(par_q[0]), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
